// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths.
package uart_pkg;

    localparam int unsigned UART_SAAT_VARS = 5208;
    localparam int unsigned UART_VERI_BIT  = 8;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        START = 2'd1,
        VERI  = 2'd2,
        DUR   = 2'd3
    } uart_durum_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; veri_o holds the head whenever bos is low.
module uart_fifo #(
    parameter int GENISLIK = 8,
    parameter int DERINLIK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push,
    input  logic [GENISLIK-1:0] veri_i,
    input  logic                pop,
    output logic [GENISLIK-1:0] veri_o,
    output logic                dolu,
    output logic                bos
);
    localparam int AW = $clog2(DERINLIK);

    logic [GENISLIK-1:0] mem_q [DERINLIK];
    logic [AW-1:0]       yaz_q;
    logic [AW-1:0]       oku_q;
    logic [AW:0]         say_q;
    logic [AW:0]         say_d;
    logic                push_ok;
    logic                pop_ok;

    // Full/empty come from the pre-edge count, so a full FIFO refuses a push
    // even when a pop happens in the same cycle.
    assign dolu    = (say_q == (AW+1)'(DERINLIK));
    assign bos     = (say_q == '0);
    assign push_ok = push && !dolu;
    assign pop_ok  = pop && !bos;
    assign veri_o  = mem_q[oku_q];

    always_comb begin
        say_d = say_q;
        case ({push_ok, pop_ok})
            2'b10:   say_d = say_q + (AW+1)'(1);
            2'b01:   say_d = say_q - (AW+1)'(1);
            default: say_d = say_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_q <= '0;
            oku_q <= '0;
            say_q <= '0;
        end else begin
            if (push_ok) begin
                yaz_q <= yaz_q + AW'(1);
            end
            if (pop_ok) begin
                oku_q <= oku_q + AW'(1);
            end
            say_q <= say_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[yaz_q] <= veri_i;
        end
    end

endmodule

// File: rtl/uart_verici.sv
// UART 8N1 transmitter: valid/ready byte input, small FIFO, LSB-first frames
// on a registered TX line that idles high.
module uart_verici
    import uart_pkg::*;
#(
    parameter int unsigned UART_SAAT     = UART_SAAT_VARS,
    parameter int          FIFO_DERINLIK = 4
) (
    input  logic       clk_g,
    input  logic       rst_g,
    input  logic [7:0] gon_veri,
    input  logic       gon_gecerli,
    output logic       gon_hazir,
    output logic       TX,
    output logic       mesgul
);
    uart_durum_e              durum_q;
    uart_durum_e              durum_d;
    logic [31:0]              sayac_q;
    logic [31:0]              sayac_d;
    logic [2:0]               indis_q;
    logic [2:0]               indis_d;
    logic [UART_VERI_BIT-1:0] kaydir_q;
    logic                     tx_q;
    logic                     tx_d;
    logic                     mesgul_q;
    logic                     mesgul_d;
    logic                     fifo_dolu;
    logic                     fifo_bos;
    logic [UART_VERI_BIT-1:0] fifo_bas;
    logic                     push_ok;
    logic                     pop;
    logic                     yukle;
    logic                     kaydir;
    logic                     bit_son;

    assign gon_hazir = !fifo_dolu;
    assign push_ok   = gon_gecerli && !fifo_dolu;
    assign bit_son   = (sayac_q == UART_SAAT);
    assign TX        = tx_q;
    assign mesgul    = mesgul_q;

    uart_fifo #(
        .GENISLIK(UART_VERI_BIT),
        .DERINLIK(FIFO_DERINLIK)
    ) u_fifo (
        .clk_i (clk_g),
        .rst_i (rst_g),
        .push  (gon_gecerli),
        .veri_i(gon_veri),
        .pop   (pop),
        .veri_o(fifo_bas),
        .dolu  (fifo_dolu),
        .bos   (fifo_bos)
    );

    always_comb begin
        durum_d = durum_q;
        sayac_d = '0;
        indis_d = indis_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        yukle   = 1'b0;
        kaydir  = 1'b0;
        if (durum_q != BOSTA) begin
            sayac_d = bit_son ? 32'd0 : sayac_q + 32'd1;
        end
        case (durum_q)
            BOSTA: begin
                tx_d = 1'b1;
                if (!fifo_bos) begin
                    pop     = 1'b1;
                    yukle   = 1'b1;
                    durum_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_son) begin
                    durum_d = VERI;
                    indis_d = 3'd0;
                    tx_d    = kaydir_q[0];
                end
            end
            VERI: begin
                if (bit_son) begin
                    if (indis_q == 3'(UART_VERI_BIT - 1)) begin
                        durum_d = DUR;
                        tx_d    = 1'b1;
                    end else begin
                        // Next data bit is bit 1 of the current shift value.
                        kaydir  = 1'b1;
                        indis_d = indis_q + 3'd1;
                        tx_d    = kaydir_q[1];
                    end
                end
            end
            DUR: begin
                if (bit_son) begin
                    if (!fifo_bos) begin
                        pop     = 1'b1;
                        yukle   = 1'b1;
                        durum_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        durum_d = BOSTA;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                durum_d = BOSTA;
                tx_d    = 1'b1;
            end
        endcase
        // Every pop leaves the FSM busy, so FIFO occupancy after the edge only
        // matters when nothing is popped.
        mesgul_d = (durum_d != BOSTA) || push_ok || !fifo_bos;
    end

    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            durum_q  <= BOSTA;
            sayac_q  <= '0;
            indis_q  <= '0;
            tx_q     <= 1'b1;
            mesgul_q <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            sayac_q  <= sayac_d;
            indis_q  <= indis_d;
            tx_q     <= tx_d;
            mesgul_q <= mesgul_d;
        end
    end

    always_ff @(posedge clk_g) begin
        if (yukle) begin
            kaydir_q <= fifo_bas;
        end else if (kaydir) begin
            kaydir_q <= {1'b0, kaydir_q[UART_VERI_BIT-1:1]};
        end
    end

endmodule

// File: tb/tb_uart_verici.sv
// Bench for uart_verici: directed scenarios plus random bytes decoded by a
// mid-bit sampling receiver and compared against a queue of accepted bytes.
module tb_uart_verici;
    localparam int SAAT = 16;
    localparam int BIT  = SAAT + 1;
    localparam int CERC = 10 * BIT;

    logic       clk_g       = 1'b0;
    logic       rst_g       = 1'b1;
    logic [7:0] gon_veri    = 8'h00;
    logic       gon_gecerli = 1'b0;
    logic       gon_hazir;
    logic       TX;
    logic       mesgul;

    int         toplam = 0;
    int         hatali = 0;
    int         cyc    = 0;
    logic [7:0] sb[$];
    int         basla_q[$];

    uart_verici #(
        .UART_SAAT    (SAAT),
        .FIFO_DERINLIK(4)
    ) dut (
        .clk_g      (clk_g),
        .rst_g      (rst_g),
        .gon_veri   (gon_veri),
        .gon_gecerli(gon_gecerli),
        .gon_hazir  (gon_hazir),
        .TX         (TX),
        .mesgul     (mesgul)
    );

    always #5 clk_g = ~clk_g;
    always @(posedge clk_g) cyc <= cyc + 1;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hatali++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", etiket, gozlenen, beklenen, cyc);
        end
    endtask

    task automatic bekle(input int n, inout bit iptal);
        repeat (n) begin
            @(negedge clk_g);
            if (rst_g) iptal = 1'b1;
        end
    endtask

    task automatic bekle_cyc(input int c);
        while (cyc < c) @(negedge clk_g);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic gonder(input logic [7:0] b);
        int n = 0;
        gon_veri    = b;
        gon_gecerli = 1'b1;
        while (gon_hazir !== 1'b1 && n < 1000) begin
            @(negedge clk_g);
            n++;
        end
        if (gon_hazir !== 1'b1) kontrol("hazir_timeout", gon_hazir, 1);
        else sb.push_back(b);
        @(negedge clk_g);
    endtask

    task automatic bosalt(input string etiket, input int sinir);
        int n = 0;
        while ((mesgul !== 1'b0 || sb.size() != 0) && n < sinir) begin
            @(negedge clk_g);
            n++;
        end
        kontrol({etiket, "_kalan"}, sb.size(), 0);
        kontrol({etiket, "_mesgul"}, mesgul, 0);
    endtask

    task automatic patlama(input string etiket, input logic [7:0] bs [6]);
        int acc[6];
        int s0;
        s0 = basla_q.size();
        for (int i = 0; i < 6; i++) begin
            gonder(bs[i]);
            acc[i] = cyc;
        end
        gon_gecerli = 1'b0;
        for (int i = 1; i < 5; i++) kontrol($sformatf("%s_kabul%0d", etiket, i), acc[i] - acc[0], i);
        kontrol({etiket, "_dolu_kabul"}, acc[5] - acc[0], CERC + 2);
        bosalt(etiket, 8 * CERC);
        kontrol({etiket, "_cerceve_sayisi"}, basla_q.size() - s0, 6);
        if (basla_q.size() > s0) kontrol({etiket, "_ilk_start"}, basla_q[s0], acc[0] + 1);
        for (int i = 1; i < 6 && s0 + i < basla_q.size(); i++)
            kontrol($sformatf("%s_bitisik%0d", etiket, i), basla_q[s0+i] - basla_q[s0+i-1], CERC);
    endtask

    // Receiver model: find a start bit, sample every bit at its centre.
    initial begin : izleyici
        logic [7:0] bayt;
        logic       basla_b;
        logic       dur_b;
        bit         iptal;
        forever begin
            @(negedge clk_g);
            if (!rst_g && TX === 1'b0) begin
                iptal = 1'b0;
                basla_q.push_back(cyc);
                bekle(8, iptal);
                basla_b = TX;
                for (int k = 0; k < 8; k++) begin
                    bekle(BIT, iptal);
                    bayt[k] = TX;
                end
                bekle(BIT, iptal);
                dur_b = TX;
                if (!iptal) begin
                    kontrol("rx_start", basla_b, 0);
                    kontrol("rx_stop", dur_b, 1);
                    if (sb.size() == 0) kontrol("rx_unexpected_frame", 1, 0);
                    else kontrol("rx_byte", bayt, sb.pop_front());
                end
            end
        end
    end

    initial begin : bekci
        repeat (95000) @(posedge clk_g);
        $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : senaryo
        int         e0;
        int         n;
        logic [9:0] cerceve;
        logic [7:0] bs [6];

        repeat (3) @(negedge clk_g);
        kontrol("rst_tx", TX, 1);
        kontrol("rst_hazir", gon_hazir, 1);
        kontrol("rst_mesgul", mesgul, 0);
        rst_g = 1'b0;
        repeat (2) @(negedge clk_g);

        // Single 0x55 frame with exact bit timing.
        gonder(8'h55);
        gon_gecerli = 1'b0;
        e0 = cyc;
        kontrol("t1_mesgul_rise", mesgul, 1);
        kontrol("t1_tx_e0", TX, 1);
        bekle_cyc(e0 + 1);
        kontrol("t1_tx_fall", TX, 0);
        cerceve = {1'b1, 8'h55, 1'b0};
        for (int j = 0; j < 10; j++) begin
            bekle_cyc(e0 + 1 + BIT * j + 8);
            kontrol($sformatf("t1_bit%0d", j), TX, cerceve[j]);
        end
        bekle_cyc(e0 + CERC);
        kontrol("t1_mesgul_end", mesgul, 1);
        bekle_cyc(e0 + CERC + 1);
        kontrol("t1_mesgul_fall", mesgul, 0);
        kontrol("t1_tx_idle", TX, 1);
        bosalt("t1", 4 * CERC);

        // Held-valid bursts that overflow the FIFO.
        for (int i = 0; i < 6; i++) bs[i] = 8'(i + 1);
        patlama("t2", bs);
        for (int i = 0; i < 5; i++) bs[i] = 8'($urandom);
        bs[5] = 8'hAA;
        patlama("t3", bs);

        // 0x00 then 0xFF: stop bit between them and start bit length.
        gonder(8'h00);
        gonder(8'hFF);
        gon_gecerli = 1'b0;
        n = 0;
        while (TX === 1'b0 && n < 300) begin @(negedge clk_g); n++; end
        n = 0;
        while (TX === 1'b1 && n < 100) begin @(negedge clk_g); n++; end
        kontrol("t4_stop_len", n, BIT);
        n = 0;
        while (TX === 1'b0 && n < 100) begin @(negedge clk_g); n++; end
        kontrol("t4_start_len", n, BIT);
        bosalt("t4", 4 * CERC);

        // Reset in the middle of bit 3 of 0x3C with two more bytes queued.
        gonder(8'h3C);
        e0 = cyc;
        gonder(8'($urandom));
        gonder(8'($urandom));
        gon_gecerli = 1'b0;
        bekle_cyc(e0 + 1 + 4 * BIT + 8);
        kontrol("t5_bit3", TX, 1);
        rst_g = 1'b1;
        #1;
        kontrol("t5_tx_async", TX, 1);
        @(negedge clk_g);
        rst_g = 1'b0;
        sb.delete();
        @(negedge clk_g);
        kontrol("t5_hazir", gon_hazir, 1);
        kontrol("t5_mesgul", mesgul, 0);
        n = 0;
        repeat (400) begin
            @(negedge clk_g);
            if (TX !== 1'b1) n++;
        end
        kontrol("t5_no_frames", n, 0);

        // Reset during a low start bit must raise TX without a clock edge.
        gonder(8'($urandom));
        gon_gecerli = 1'b0;
        e0 = cyc;
        bekle_cyc(e0 + 5);
        kontrol("t5b_start_low", TX, 0);
        rst_g = 1'b1;
        #1;
        kontrol("t5b_tx_async", TX, 1);
        @(negedge clk_g);
        rst_g = 1'b0;
        sb.delete();
        repeat (200) @(negedge clk_g);
        kontrol("t5b_mesgul", mesgul, 0);

        // Random bytes with random gaps, decoded by the receiver model.
        for (int i = 0; i < 300; i++) begin
            gon_gecerli = 1'b0;
            if ($urandom_range(0, 19) == 0) repeat (200) @(negedge clk_g);
            else repeat ($urandom_range(0, 2)) @(negedge clk_g);
            gonder(8'($urandom));
        end
        gon_gecerli = 1'b0;
        bosalt("t6", 8 * CERC);

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule
